map_port_arbiter: RTL
=====================

Name: map_port_arbiter

Overview:
- Shares the two combinational read ports of the 32x32 maze bitmap between N_REQ tile-query requesters (player movement, ghost AI, pellet logic).
- Each requester asks "is tile (x,y) a wall?" and receives one registered bit.
- Grants up to two requesters per cycle, round-robin. Sits between the game-logic movers and the maze ROM.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- STALL_W, 16, width of the per-requester stall counters (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester query request, level
- x_in  in  5*N_REQ  packed tile column; requester i uses bits [5i+4:5i]
- y_in  in  5*N_REQ  packed tile row; same packing
- gnt  out  N_REQ  combinational accept strobe
- rsp_valid  out  N_REQ  registered response strobe
- rsp_wall  out  N_REQ  registered wall bit; 1 = wall, 0 = open
- map_addr_a  out  5  row address to map read port A
- map_addr_b  out  5  row address to map read port B
- map_data_a  in  32  row data from port A (combinational ROM)
- map_data_b  in  32  row data from port B

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Handshake:
  - A query is accepted in cycle T when req[i] & gnt[i].
  - x/y are sampled in T.
  - rsp_valid[i] = 1 and rsp_wall[i] are valid in T+1, for exactly one cycle.
  - Requester may hold req high with new coordinates in T+1 (back-to-back queries allowed).
  - A requester not granted must hold x/y stable.
- Arbitration (combinational, from req and rr_ptr):
  - slot A = first i with req[i] set, scanning cyclically from rr_ptr.
  - slot B = next set req after slot A, cyclically, distinct from A.
  - 0, 1 or 2 grants per cycle; at most one grant per requester per cycle.
- Port drive:
  - map_addr_a = y of slot A; map_addr_b = y of slot B.
  - An unused port drives address 0.
- Bit select: wall = map_data[31 - x]. Column 0 is the MSB (leftmost) of the row word.
- Response register: rsp_wall[i] <= selected bit on grant; otherwise hold the previous value. rsp_valid[i] <= gnt[i].
- Pointer update:
  - If any grant, rr_ptr <= (last granted index + 1) mod N_REQ. Last granted is slot B if present, else slot A.
  - With no grants, rr_ptr holds.
- Fairness: a continuously requesting requester is granted within ceil(N_REQ/2) cycles.
- Reset values: rr_ptr = 0, rsp_valid = 0, rsp_wall = 0. gnt is forced to 0 while reset is high.
- Reset mid-operation: a grant issued in the cycle before reset rises still produces rsp_valid, unless reset is high in that response cycle, in which case the response is dropped (rsp_valid = 0). No queued state survives reset.
- Coordinates are 5-bit: wrap-around (tunnel row x = 31 -> 0) is the mover's concern; all 32 values are legal.
- Two requesters asking for the same row are each served on their own port. There is no merging.

Optional Feature:
- Macro MAP_ARB_STALL_STATS_EN.
- With it defined:
  - Output port stall_cnt (out, STALL_W*N_REQ).
  - Per requester, counts cycles with req[i] & ~gnt[i]; saturates at all-ones.
  - Cleared by reset.
  - Extra input stall_clr (in, 1) clears all counters synchronously; clear takes priority over increment.
- Without it: stall_cnt, stall_clr and the counter logic do not exist. Behaviour is otherwise identical.

Decomposition:
- Package map_pkg:
  - TILE_W = 5, MAP_ROWS = 32, ROW_W = 32.
  - Typedef tile_coord_t (5-bit).
  - Function wall_bit(row, x) returning row[31 - x].
- One sub-module, rr_find_next: given a request vector, start index and exclude mask, returns found flag and index. It is instantiated twice, for slot A and for slot B (slot B excludes slot A's index and starts one index after it).

Test Plan:
- Single requester 0, y = 0x0F, x = 0 -> gnt[0] same cycle; rsp_valid[0] = 1, rsp_wall[0] = 1 next cycle. Then x = 1 -> rsp_wall[0] = 0.
- Requesters 0 and 1 in the same cycle, (x = 3, y = 2) and (x = 4, y = 2) -> both granted; map_addr_a = map_addr_b = 2; next cycle rsp_wall = {1, 0} for {req0, req1}.
- All four requesting continuously for 8 cycles -> grant pairs {0,1}, {2,3}, {0,1}, ...; each requester gets 4 grants.
- Requesters 1 and 3 only, rr_ptr = 2 -> slot A = 3, slot B = 1; rr_ptr becomes 2.
- Grant at T with reset high at T+1 -> rsp_valid = 0 at T+1; rr_ptr = 0 afterwards.
- MAP_ARB_STALL_STATS_EN: 4 requesters continuously for 10 cycles -> each stall_cnt = 5. Then stall_clr -> all counters 0 the next cycle.

Source files
------------

// File: rtl/map_pkg.sv
// Shared maze-map types and helpers for the tile-query arbiter.
// Rows are 32-bit words; column 0 is the MSB of each row.
package map_pkg;

    localparam int TILE_W   = 5;
    localparam int MAP_ROWS = 32;
    localparam int ROW_W    = 32;

    typedef logic [TILE_W-1:0]            tile_coord_t;
    typedef logic [$clog2(MAP_ROWS)-1:0]  row_addr_t;
    typedef logic [ROW_W-1:0]             map_row_t;

    function automatic logic wall_bit(
        input map_row_t    row,
        input tile_coord_t x
    );
        tile_coord_t sel;
        sel = tile_coord_t'(ROW_W - 1) - x;
        return row[sel];
    endfunction

endpackage

// File: rtl/rr_find_next.sv
// Cyclic first-set finder: scans req & ~excl starting at start.
// Used twice by map_port_arbiter to pick the two port slots.
module rr_find_next #(
    parameter int N = 4
) (
    input  logic [N-1:0]                    req,
    input  logic [$clog2(N)-1:0]            start,
    input  logic [N-1:0]                    excl,
    output logic                            found,
    output logic [$clog2(N)-1:0]            idx
);

    localparam int IW = $clog2(N);

    logic [N-1:0] cand;
    int           j;

    assign cand = req & ~excl;

    // Scan from the far end so the candidate nearest start wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (cand[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/map_port_arbiter.sv
// Round-robin sharing of the two maze-ROM read ports between N_REQ movers.
// Optional per-requester stall counters: define MAP_ARB_STALL_STATS_EN.
module map_port_arbiter
    import map_pkg::*;
#(
    parameter int N_REQ = 4
`ifdef MAP_ARB_STALL_STATS_EN
    ,
    parameter int STALL_W = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef MAP_ARB_STALL_STATS_EN
    input  logic                       stall_clr,
    output logic [STALL_W*N_REQ-1:0]   stall_cnt,
`endif
    input  logic [N_REQ-1:0]           req,
    input  logic [TILE_W*N_REQ-1:0]    x_in,
    input  logic [TILE_W*N_REQ-1:0]    y_in,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [N_REQ-1:0]           rsp_wall,
    output row_addr_t                  map_addr_a,
    output row_addr_t                  map_addr_b,
    input  map_row_t                   map_data_a,
    input  map_row_t                   map_data_b
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     idx_a;
    logic [IW-1:0]     idx_b;
    logic [IW-1:0]     start_b;
    logic              found_a;
    logic              found_b;
    logic [N_REQ-1:0]  req_b;
    logic [N_REQ-1:0]  excl_b;
    logic [N_REQ-1:0]  gnt_a;
    logic [N_REQ-1:0]  gnt_b;
    logic [N_REQ-1:0]  rsp_valid_q;
    tile_coord_t       xs [N_REQ];
    tile_coord_t       ys [N_REQ];
    tile_coord_t       x_a;
    tile_coord_t       x_b;
    logic              wall_a;
    logic              wall_b;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign xs[g] = x_in[TILE_W*g +: TILE_W];
        assign ys[g] = y_in[TILE_W*g +: TILE_W];
    end

    rr_find_next #(.N(N_REQ)) u_find_a (
        .req   (req),
        .start (rr_ptr),
        .excl  ('0),
        .found (found_a),
        .idx   (idx_a)
    );

    // Slot B only exists once slot A does, and never repeats it.
    assign start_b = wrap_inc(idx_a);
    assign excl_b  = N_REQ'(1) << idx_a;
    assign req_b   = found_a ? req : '0;

    rr_find_next #(.N(N_REQ)) u_find_b (
        .req   (req_b),
        .start (start_b),
        .excl  (excl_b),
        .found (found_b),
        .idx   (idx_b)
    );

    assign gnt_a = (found_a && !reset) ? (N_REQ'(1) << idx_a) : '0;
    assign gnt_b = (found_b && !reset) ? (N_REQ'(1) << idx_b) : '0;
    assign gnt   = gnt_a | gnt_b;

    assign map_addr_a = found_a ? row_addr_t'(ys[idx_a]) : '0;
    assign map_addr_b = found_b ? row_addr_t'(ys[idx_b]) : '0;

    assign x_a    = xs[idx_a];
    assign x_b    = xs[idx_b];
    assign wall_a = wall_bit(map_data_a, x_a);
    assign wall_b = wall_bit(map_data_b, x_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            rsp_valid_q <= '0;
            rsp_wall    <= '0;
        end else begin
            rsp_valid_q <= gnt;
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_a[i]) begin
                    rsp_wall[i] <= wall_a;
                end else if (gnt_b[i]) begin
                    rsp_wall[i] <= wall_b;
                end
            end
            if (found_a) begin
                rr_ptr <= found_b ? wrap_inc(idx_b) : wrap_inc(idx_a);
            end
        end
    end

    // A response landing in a reset cycle is dropped.
    assign rsp_valid = rsp_valid_q & {N_REQ{~reset}};

`ifdef MAP_ARB_STALL_STATS_EN
    logic [STALL_W-1:0] stall_q [N_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (reset || stall_clr) begin
                stall_q[i] <= '0;
            end else if (req[i] && !gnt[i] && (stall_q[i] != '1)) begin
                stall_q[i] <= stall_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stall_cnt[STALL_W*i +: STALL_W] = stall_q[i];
        end
    end
`endif

endmodule
